// File: rtl/rf_warb_pkg.sv
// Shared types and defaults for the register-file write arbiter.
// No logic; no latency; no backpressure.
// The types below describe the default configuration (4 requesters, 5-bit address, 32-bit data).
package rf_warb_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int PERF_CNT_W     = 32;

    typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_idx_t;

    typedef struct packed {
        logic                      we;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0] data;
    } wr_port_t;

    // Circular successor of idx within 0..n-1.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rf_warb_rr_pick.sv
// Circular find-first-set: first set bit of vec at or after start, wrapping past N-1 to 0.
// Latency: purely combinational.
// Backpressure: none; found=0 when vec is empty.
module rf_warb_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scanning from the far end lets the nearest hit overwrite later ones.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (vec[(int'(start) + k) % N]) begin
                found = 1'b1;
                idx   = IW'((int'(start) + k) % N);
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter granting up to two of NUM_REQ writers onto the A/B register-file write ports.
// Latency: accept in cycle N, we/waddr/wdata driven in cycle N+1; ready is combinational.
// Backpressure: ungranted or same-address-deferred requesters see ready=0 and hold. Macro RF_WARB_PERF_EN adds counters.
module rf_write_arbiter
    import rf_warb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [ADDR_WIDTH-1:0]         waddr_a_o,
    output logic [DATA_WIDTH-1:0]         wdata_a_o,
    output logic                          we_a_o,
    output logic [ADDR_WIDTH-1:0]         waddr_b_o,
    output logic [DATA_WIDTH-1:0]         wdata_b_o,
    output logic                          we_b_o,
    output logic                          busy_o
`ifdef RF_WARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]         conflict_cnt_o,
    output logic [PERF_CNT_W-1:0]         stall_cnt_o
`endif
);

    localparam int IW = $clog2(NUM_REQ);

    typedef logic [IW-1:0] idx_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } port_t;

    idx_t                  rr_ptr;
    idx_t                  g1_idx;
    idx_t                  g2_idx;
    idx_t                  g2_start;
    logic                  g1_found;
    logic                  g2_found;
    logic                  conflict;
    logic                  g1_take;
    logic                  g2_take;
    logic [NUM_REQ-1:0]    g2_vec;
    logic [NUM_REQ-1:0]    ready;
    logic [ADDR_WIDTH-1:0] g1_addr;
    logic [ADDR_WIDTH-1:0] g2_addr;
    logic [DATA_WIDTH-1:0] g1_data;
    logic [DATA_WIDTH-1:0] g2_data;
    port_t                 port_a;
    port_t                 port_b;

    rf_warb_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick_a (
        .vec   (req_valid_i),
        .start (rr_ptr),
        .found (g1_found),
        .idx   (g1_idx)
    );

    // Second pick scans on from just after grant 1, with grant 1 removed.
    assign g2_start = idx_t'(wrap_inc(int'(g1_idx), NUM_REQ));
    assign g2_vec   = req_valid_i & ~({{(NUM_REQ-1){1'b0}}, 1'b1} << g1_idx);

    rf_warb_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick_b (
        .vec   (g2_vec),
        .start (g2_start),
        .found (g2_found),
        .idx   (g2_idx)
    );

    assign g1_addr = req_addr_i[int'(g1_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign g2_addr = req_addr_i[int'(g2_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign g1_data = req_data_i[int'(g1_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign g2_data = req_data_i[int'(g2_idx)*DATA_WIDTH +: DATA_WIDTH];

    // Both ports never target the same register, so the file needs no port priority.
    assign conflict = g1_found & g2_found & (g1_addr == g2_addr);
    assign g1_take  = g1_found & ~rst;
    assign g2_take  = g2_found & ~conflict & ~rst;

    always_comb begin
        ready = '0;
        if (g1_take) ready[g1_idx] = 1'b1;
        if (g2_take) ready[g2_idx] = 1'b1;
    end

    assign req_ready_o = ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (g2_take) begin
            rr_ptr <= idx_t'(wrap_inc(int'(g2_idx), NUM_REQ));
        end else if (g1_take) begin
            rr_ptr <= idx_t'(wrap_inc(int'(g1_idx), NUM_REQ));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_a <= '0;
            port_b <= '0;
        end else begin
            port_a.we <= g1_take;
            port_b.we <= g2_take;
            if (g1_take) begin
                port_a.addr <= g1_addr;
                port_a.data <= g1_data;
            end
            if (g2_take) begin
                port_b.addr <= g2_addr;
                port_b.data <= g2_data;
            end
        end
    end

    // Gating with rst drops a write already registered when reset arrives.
    assign we_a_o    = port_a.we & ~rst;
    assign we_b_o    = port_b.we & ~rst;
    assign waddr_a_o = port_a.addr;
    assign wdata_a_o = port_a.data;
    assign waddr_b_o = port_b.addr;
    assign wdata_b_o = port_b.data;
    assign busy_o    = we_a_o | we_b_o;

`ifdef RF_WARB_PERF_EN
    logic stall;

    assign stall = |(req_valid_i & ~ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_o <= '0;
            stall_cnt_o    <= '0;
        end else begin
            if (conflict && (conflict_cnt_o != '1)) conflict_cnt_o <= conflict_cnt_o + 1'b1;
            if (stall && (stall_cnt_o != '1))       stall_cnt_o    <= stall_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized bench for rf_write_arbiter against a request-level round-robin model.
module tb_rf_write_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic [4:0]   waddr_a;
    logic [31:0]  wdata_a;
    logic         we_a;
    logic [4:0]   waddr_b;
    logic [31:0]  wdata_b;
    logic         we_b;
    logic         busy;
`ifdef RF_WARB_PERF_EN
    logic [31:0]  conflict_cnt;
    logic [31:0]  stall_cnt;
`endif

    rf_write_arbiter #(
        .NUM_REQ    (4),
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .waddr_a_o   (waddr_a),
        .wdata_a_o   (wdata_a),
        .we_a_o      (we_a),
        .waddr_b_o   (waddr_b),
        .wdata_b_o   (wdata_b),
        .we_b_o      (we_b),
        .busy_o      (busy)
`ifdef RF_WARB_PERF_EN
        ,
        .conflict_cnt_o (conflict_cnt),
        .stall_cnt_o    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Requester-side view: what each unit is currently asking for.
    bit          pend_v [4];
    logic [4:0]  pend_a [4];
    logic [31:0] pend_d [4];

    // Model of rotation pointer and of what the register file should see.
    int          m_rr;
    logic        e_we_a, e_we_b;
    logic [4:0]  e_addr_a, e_addr_b;
    logic [31:0] e_data_a, e_data_b;
    int          m_conf_cnt, m_stall_cnt;
    logic [3:0]  obs_ready;
    logic        obs_we_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        pend_v[i] = 1'b1;
        pend_a[i] = a;
        pend_d[i] = d;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]          = pend_v[i];
            req_addr[i*5 +: 5]    = pend_a[i];
            req_data[i*32 +: 32]  = pend_d[i];
        end
    endtask

    // Grant 1: first pending at/after pointer; grant 2: next pending after it, unless same address.
    task automatic model_grants(output int g1, output int g2, output bit conf);
        g1   = -1;
        g2   = -1;
        conf = 1'b0;
        if (rst) return;
        for (int k = 0; k < 4; k++)
            if (g1 < 0 && pend_v[(m_rr + k) % 4]) g1 = (m_rr + k) % 4;
        if (g1 < 0) return;
        for (int k = 1; k < 4; k++)
            if (g2 < 0 && pend_v[(g1 + k) % 4]) g2 = (g1 + k) % 4;
        if (g2 >= 0 && pend_a[g2] == pend_a[g1]) begin
            g2   = -1;
            conf = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_rr        = 0;
        e_we_a      = 1'b0;
        e_we_b      = 1'b0;
        e_addr_a    = '0;
        e_addr_b    = '0;
        e_data_a    = '0;
        e_data_b    = '0;
        m_conf_cnt  = 0;
        m_stall_cnt = 0;
    endtask

    task automatic run_cycle();
        int         g1, g2;
        bit         conf, stl;
        logic [3:0] er;
        drive();
        @(negedge clk);
        model_grants(g1, g2, conf);
        er = '0;
        if (g1 >= 0) er[g1] = 1'b1;
        if (g2 >= 0) er[g2] = 1'b1;
        stl = 1'b0;
        for (int i = 0; i < 4; i++)
            if (!rst && pend_v[i] && !er[i]) stl = 1'b1;
        obs_ready = req_ready;
        obs_we_a  = we_a;
        chk("ready",   req_ready, er);
        chk("we_a",    we_a, e_we_a & ~rst);
        chk("we_b",    we_b, e_we_b & ~rst);
        chk("busy",    busy, (e_we_a | e_we_b) & ~rst);
        chk("waddr_a", waddr_a, e_addr_a);
        chk("wdata_a", wdata_a, e_data_a);
        chk("waddr_b", waddr_b, e_addr_b);
        chk("wdata_b", wdata_b, e_data_b);
`ifdef RF_WARB_PERF_EN
        chk("conflict_cnt", conflict_cnt, m_conf_cnt);
        chk("stall_cnt",    stall_cnt, m_stall_cnt);
`endif
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            e_we_a = (g1 >= 0);
            e_we_b = (g2 >= 0);
            if (g1 >= 0) begin
                e_addr_a   = pend_a[g1];
                e_data_a   = pend_d[g1];
                pend_v[g1] = 1'b0;
                m_rr       = (g1 + 1) % 4;
            end
            if (g2 >= 0) begin
                e_addr_b   = pend_a[g2];
                e_data_b   = pend_d[g2];
                pend_v[g2] = 1'b0;
                m_rr       = (g2 + 1) % 4;
            end
            if (conf) m_conf_cnt++;
            if (stl)  m_stall_cnt++;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            pend_v[i] = 1'b0;
            pend_a[i] = '0;
            pend_d[i] = '0;
        end
        // All four valid during reset, addresses 1..4.
        for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'h1000_0000 + i);
        rst = 1'b1;
        drive();
        @(posedge clk);
        #1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            run_cycle();
            chk("rst_ready", obs_ready, 4'b0000);
            chk("rst_we_a",  obs_we_a, 1'b0);
        end
        rst = 1'b0;

        // Four distinct writers from pointer 0: pairs (0,1) then (2,3).
        run_cycle();
        chk("t1_ready0", obs_ready, 4'b0011);
        chk("t1_wa0",    waddr_a, 5'd1);
        chk("t1_wb0",    waddr_b, 5'd2);
        chk("t1_web0",   we_b, 1'b1);
        run_cycle();
        chk("t1_ready1", obs_ready, 4'b1100);
        chk("t1_wa1",    waddr_a, 5'd3);
        chk("t1_wb1",    waddr_b, 5'd4);

        // Same address on requesters 1 and 2: second one deferred a cycle.
        set_req(1, 5'd7, 32'hAAAA_0001);
        set_req(2, 5'd7, 32'hAAAA_0002);
        run_cycle();
        chk("t2_ready0", obs_ready, 4'b0010);
`ifdef RF_WARB_PERF_EN
        chk("t2_conflicts", conflict_cnt, 32'd1);
`endif
        run_cycle();
        chk("t2_ready1", obs_ready, 4'b0100);
        chk("t2_we_a",   we_a, 1'b1);
        chk("t2_waddr",  waddr_a, 5'd7);
        chk("t2_wdata",  wdata_a, 32'hAAAA_0002);
        chk("t2_we_b",   we_b, 1'b0);
        run_cycle();

        // Lone requester 3 at the top address.
        set_req(3, 5'd31, 32'hDEAD_BEEF);
        run_cycle();
        chk("t3_ready", obs_ready, 4'b1000);
        chk("t3_we_a",  we_a, 1'b1);
        chk("t3_wdata", wdata_a, 32'hDEAD_BEEF);
        chk("t3_waddr", waddr_a, 5'd31);
        chk("t3_we_b",  we_b, 1'b0);

        // Move pointer to 3, then requesters 3 and 0 wrap around.
        set_req(2, 5'd9, 32'h2222_2222);
        run_cycle();
        set_req(3, 5'd12, 32'h3333_3333);
        set_req(0, 5'd13, 32'h0000_0000);
        run_cycle();
        chk("t4_ready",  obs_ready, 4'b1001);
        chk("t4_waddr_a", waddr_a, 5'd12);
        chk("t4_waddr_b", waddr_b, 5'd13);
        // Pointer now 1: requester 1 must win port A over requester 0.
        set_req(0, 5'd20, 32'h0000_0020);
        set_req(1, 5'd21, 32'h0000_0021);
        run_cycle();
        chk("t4_ready2",  obs_ready, 4'b0011);
        chk("t4_waddr_a2", waddr_a, 5'd21);
        chk("t4_waddr_b2", waddr_b, 5'd20);

        // Reset in the cycle after an accept: the write must never appear.
        set_req(2, 5'd5, 32'h5555_5555);
        run_cycle();
        set_req(0, 5'd6, 32'h6666_6666);
        rst = 1'b1;
        run_cycle();
        chk("t5_dropped", obs_we_a, 1'b0);
        chk("t5_ready",   obs_ready, 4'b0000);
        rst = 1'b0;
        run_cycle();
        chk("t5_held_req", obs_ready, 4'b0001);

        // Random traffic with narrow addresses to provoke conflicts, occasional reset.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend_v[i] && ($urandom_range(0, 2) != 0)) begin
                    if (c < 1500) set_req(i, 5'($urandom_range(0, 3)), $urandom);
                    else          set_req(i, 5'($urandom_range(0, 31)), $urandom);
                end
            end
            rst = ($urandom_range(0, 99) == 0);
            run_cycle();
        end
        rst = 1'b0;
        run_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
